// File: rtl/fb_read_arbiter_pkg.sv
// Shared constants and types for the frame-buffer read arbiter.
package fb_read_arbiter_pkg;

    localparam int FB_ADDR_W          = 16;
    localparam int FB_DATA_W          = 3;
    localparam int DEFAULT_MEM_LAT    = 1;
    localparam int DEFAULT_STARVE_MAX = 8;

    // Owner tag carried down the return pipe alongside each read.
    localparam logic OWNER_V = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef enum logic {
        ARB_NORMAL  = 1'b0,
        ARB_FORCE_D = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic valid;
        logic owner;
    } ret_tag_t;

endpackage

// File: rtl/fb_read_arbiter_rd_return_pipe.sv
// Delays the {valid, owner} tag of each issued read by MEM_LAT cycles and
// steers the memory read data back to whichever port issued that read.
module rd_return_pipe
    import fb_read_arbiter_pkg::*;
#(
    parameter int MEM_LAT = DEFAULT_MEM_LAT,
    parameter int DATA_W  = FB_DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              issue_valid,
    input  logic              issue_owner,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              dmp_rvalid,
    output logic [DATA_W-1:0] dmp_rdata
);

    ret_tag_t [MEM_LAT-1:0] tag_q;
    ret_tag_t [MEM_LAT-1:0] tag_d;
    ret_tag_t               tag_out;
    logic [DATA_W-1:0]      vga_rdata_q;
    logic [DATA_W-1:0]      vga_rdata_d;
    logic [DATA_W-1:0]      dmp_rdata_q;
    logic [DATA_W-1:0]      dmp_rdata_d;

    // Shift the tag line by one stage; stage 0 captures this cycle's issue.
    always_comb begin
        tag_d          = tag_q;
        tag_d[0].valid = issue_valid;
        tag_d[0].owner = issue_owner;
        for (int i = 1; i < MEM_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // The last stage lines up with mem_dout; a clearing cycle suppresses it so
    // reads caught by the reset never surface.
    always_comb begin
        tag_out    = tag_q[MEM_LAT-1];
        vga_rvalid = ~clr & tag_out.valid & (tag_out.owner == OWNER_V);
        dmp_rvalid = ~clr & tag_out.valid & (tag_out.owner == OWNER_D);
    end

    // Each port sees fresh memory data on its return cycle and keeps the last
    // returned pixel otherwise.
    always_comb begin
        vga_rdata_d = vga_rvalid ? mem_dout : vga_rdata_q;
        dmp_rdata_d = dmp_rvalid ? mem_dout : dmp_rdata_q;
    end

    assign vga_rdata = vga_rdata_d;
    assign dmp_rdata = dmp_rdata_d;

    // Tag line and held read data registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            tag_q       <= '0;
            vga_rdata_q <= '0;
            dmp_rdata_q <= '0;
        end else begin
            tag_q       <= tag_d;
            vga_rdata_q <= vga_rdata_d;
            dmp_rdata_q <= dmp_rdata_d;
        end
    end

endmodule

// File: rtl/fb_read_arbiter.sv
// Arbitrates the frame-buffer read port between VGA scan-out (priority) and
// the frame-dump reader, with a starvation guard that forces a dump slot.
module fb_read_arbiter
    import fb_read_arbiter_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int MEM_LAT    = DEFAULT_MEM_LAT,
    parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              dmp_req,
    input  logic [ADDR_W-1:0] dmp_addr,
    output logic              dmp_gnt,
    output logic              dmp_rvalid,
    output logic [DATA_W-1:0] dmp_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              starved
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    arb_state_e arb_st_q;
    arb_state_e arb_st_d;
    logic [7:0] starve_cnt_q;
    logic [7:0] starve_cnt_d;

    // Grant selection: V has priority normally, D has priority once starved.
    always_comb begin
        vga_gnt = 1'b0;
        dmp_gnt = 1'b0;
        if (!clr) begin
            unique case (arb_st_q)
                ARB_NORMAL: begin
                    vga_gnt = vga_req;
                    dmp_gnt = dmp_req & ~vga_req;
                end
                ARB_FORCE_D: begin
                    dmp_gnt = dmp_req;
                    vga_gnt = vga_req & ~dmp_req;
                end
                default: begin
                    vga_gnt = 1'b0;
                    dmp_gnt = 1'b0;
                end
            endcase
        end
    end

    // Memory request: winner's address, zero when idle.
    always_comb begin
        mem_en   = vga_gnt | dmp_gnt;
        mem_addr = '0;
        if (vga_gnt) begin
            mem_addr = vga_addr;
        end else if (dmp_gnt) begin
            mem_addr = dmp_addr;
        end
    end

    // Count consecutive cycles D waited; any grant or withdrawn request clears it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (dmp_gnt || !dmp_req) begin
            starve_cnt_d = 8'd0;
        end else if (starve_cnt_q < STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    // Enter FORCE_D when the wait count hits the limit; leave once D is served or gone.
    always_comb begin
        arb_st_d = arb_st_q;
        unique case (arb_st_q)
            ARB_NORMAL: begin
                if (starve_cnt_d == STARVE_LIM) begin
                    arb_st_d = ARB_FORCE_D;
                end
            end
            ARB_FORCE_D: begin
                if (dmp_gnt || !dmp_req) begin
                    arb_st_d = ARB_NORMAL;
                end
            end
            default: arb_st_d = ARB_NORMAL;
        endcase
    end

    assign starved = (arb_st_q == ARB_FORCE_D);

    // Arbiter state and starvation counter registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            arb_st_q     <= ARB_NORMAL;
            starve_cnt_q <= 8'd0;
        end else begin
            arb_st_q     <= arb_st_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    rd_return_pipe #(
        .MEM_LAT (MEM_LAT),
        .DATA_W  (DATA_W)
    ) u_ret (
        .clk         (clk),
        .clr         (clr),
        .issue_valid (mem_en),
        .issue_owner (dmp_gnt),
        .mem_dout    (mem_dout),
        .vga_rvalid  (vga_rvalid),
        .vga_rdata   (vga_rdata),
        .dmp_rvalid  (dmp_rvalid),
        .dmp_rdata   (dmp_rdata)
    );

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Self-checking bench for fb_read_arbiter: vector table, directed corner
// sequences and constrained-random traffic against a transaction-level model.
module tb_fb_read_arbiter;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 3;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 8;

    logic              clk;
    logic              clr;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;
    logic              dmp_req;
    logic [ADDR_W-1:0] dmp_addr;
    logic              dmp_gnt;
    logic              dmp_rvalid;
    logic [DATA_W-1:0] dmp_rdata;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic              starved;

    fb_read_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (vga_gnt),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata),
        .dmp_req    (dmp_req),
        .dmp_addr   (dmp_addr),
        .dmp_gnt    (dmp_gnt),
        .dmp_rvalid (dmp_rvalid),
        .dmp_rdata  (dmp_rdata),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .starved    (starved)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-buffer image: a fixed pixel code per address.
    function automatic logic [DATA_W-1:0] pix(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] t;
        t = a * 16'd2 + 16'd3 + (a >> 5);
        return t[DATA_W-1:0];
    endfunction

    // Synchronous memory with MEM_LAT cycles of read latency.
    logic [ADDR_W-1:0] addr_pipe [MEM_LAT];
    always @(posedge clk) begin
        addr_pipe[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
    end
    assign mem_dout = pix(addr_pipe[MEM_LAT-1]);

    int pass_count  = 0;
    int check_count = 0;
    int cyc         = 0;
    bit check_en    = 1'b0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // Transaction-level reference: outstanding reads with their due cycle.
    typedef struct {
        int                due;
        logic              owner;
        logic [ADDR_W-1:0] addr;
    } ret_t;

    ret_t              ret_q [$];
    int                lost = 0;
    logic [DATA_W-1:0] last_v = '0;
    logic [DATA_W-1:0] last_d = '0;
    int                vga_rv_cnt = 0;
    int                dmp_rv_cnt = 0;
    logic [DATA_W-1:0] vga_data_seen [$];
    logic              vg_seen = 1'b0;
    logic              dg_seen = 1'b0;

    // Every-cycle scoreboard, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        logic              exp_vg, exp_dg, exp_vrv, exp_drv;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_vd, exp_dd;
        if (check_en) begin
            exp_vg = 1'b0;
            exp_dg = 1'b0;
            if (!clr) begin
                exp_dg = dmp_req && ((lost >= STARVE_MAX) || !vga_req);
                exp_vg = vga_req && !exp_dg;
            end
            exp_addr = exp_vg ? vga_addr : (exp_dg ? dmp_addr : '0);
            exp_vrv = 1'b0;
            exp_drv = 1'b0;
            exp_vd  = last_v;
            exp_dd  = last_d;
            if (ret_q.size() > 0 && ret_q[0].due == cyc && !clr) begin
                if (ret_q[0].owner) begin
                    exp_drv = 1'b1;
                    exp_dd  = pix(ret_q[0].addr);
                end else begin
                    exp_vrv = 1'b1;
                    exp_vd  = pix(ret_q[0].addr);
                end
                void'(ret_q.pop_front());
            end
            checkOutput("vga_gnt", 32'(vga_gnt), 32'(exp_vg));
            checkOutput("dmp_gnt", 32'(dmp_gnt), 32'(exp_dg));
            checkOutput("mem_addr", 32'(mem_addr), 32'(exp_addr));
            checkOutput("starved", 32'(starved), 32'(lost >= STARVE_MAX));
            checkOutput("vga_rvalid", 32'(vga_rvalid), 32'(exp_vrv));
            checkOutput("dmp_rvalid", 32'(dmp_rvalid), 32'(exp_drv));
            checkOutput("vga_rdata", 32'(vga_rdata), 32'(exp_vd));
            checkOutput("dmp_rdata", 32'(dmp_rdata), 32'(exp_dd));
            checkOutput("one_grant", 32'(vga_gnt & dmp_gnt), 32'd0);
            checkOutput("gnt_needs_req", 32'((vga_gnt & ~vga_req) | (dmp_gnt & ~dmp_req)), 32'd0);
            checkOutput("mem_en_or", 32'(mem_en), 32'(vga_gnt | dmp_gnt));
            last_v = exp_vd;
            last_d = exp_dd;
            if (vga_rvalid) begin
                vga_rv_cnt++;
                vga_data_seen.push_back(vga_rdata);
            end
            if (dmp_rvalid) dmp_rv_cnt++;
            if (clr) begin
                ret_q.delete();
                lost   = 0;
                last_v = '0;
                last_d = '0;
            end else begin
                if (exp_vg || exp_dg) ret_q.push_back('{cyc + MEM_LAT, exp_dg, exp_addr});
                if (dmp_req && !exp_dg) lost = (lost < STARVE_MAX) ? lost + 1 : STARVE_MAX;
                else lost = 0;
            end
            vg_seen = vga_gnt;
            dg_seen = dmp_gnt;
        end
    end

    task automatic applyStimulus(input logic c, input logic vr, input logic [ADDR_W-1:0] va,
                                 input logic dr, input logic [ADDR_W-1:0] da);
        @(posedge clk);
        #1;
        clr      = c;
        vga_req  = vr;
        vga_addr = va;
        dmp_req  = dr;
        dmp_addr = da;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    typedef struct {
        logic              c;
        logic              vr;
        logic [ADDR_W-1:0] va;
        logic              dr;
        logic [ADDR_W-1:0] da;
        logic              evg;
        logic              edg;
        logic [ADDR_W-1:0] eaddr;
    } vec_t;

    vec_t              vecs [8];
    logic [DATA_W-1:0] t1_exp [3];
    int                v0, d0, dumped;
    logic [ADDR_W-1:0] va, da;
    logic              vr, dr;

    initial begin
        clr = 1'b1; vga_req = 1'b0; vga_addr = '0; dmp_req = 1'b0; dmp_addr = '0;
        t1_exp = '{3'd3, 3'd5, 3'd7};
        vecs[0] = '{1'b1, 1'b1, 16'h0003, 1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0005};
        vecs[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0009, 1'b0, 1'b1, 16'h0009};
        vecs[3] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[4] = '{1'b0, 1'b1, 16'h1234, 1'b1, 16'h0055, 1'b1, 1'b0, 16'h1234};
        vecs[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0055, 1'b0, 1'b1, 16'h0055};
        vecs[6] = '{1'b0, 1'b1, 16'h0007, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0007};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};

        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
        check_en = 1'b1;
        @(negedge clk);
        checkOutput("rst_vga_rvalid", 32'(vga_rvalid), 32'd0);
        checkOutput("rst_dmp_rdata", 32'(dmp_rdata), 32'd0);
        checkOutput("rst_starved", 32'(starved), 32'd0);

        $display("[TB] vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].c, vecs[i].vr, vecs[i].va, vecs[i].dr, vecs[i].da);
            @(negedge clk);
            checkOutput("tbl_vga_gnt", 32'(vga_gnt), 32'(vecs[i].evg));
            checkOutput("tbl_dmp_gnt", 32'(dmp_gnt), 32'(vecs[i].edg));
            checkOutput("tbl_mem_en", 32'(mem_en), 32'(vecs[i].evg | vecs[i].edg));
            checkOutput("tbl_mem_addr", 32'(mem_addr), 32'(vecs[i].eaddr));
        end

        $display("[TB] V-only reads of addresses 0,1,2");
        idle(4);
        vga_data_seen.delete();
        d0 = dmp_rv_cnt;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 16'(k), 1'b0, '0);
            @(negedge clk);
            checkOutput("t1_vga_gnt", 32'(vga_gnt), 32'd1);
            applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
        end
        idle(MEM_LAT + 2);
        checkOutput("t1_ret_count", 32'(vga_data_seen.size()), 32'd3);
        for (int k = 0; k < 3 && k < vga_data_seen.size(); k++)
            checkOutput("t1_ret_data", 32'(vga_data_seen[k]), 32'(t1_exp[k]));
        checkOutput("t1_no_dmp_rvalid", 32'(dmp_rv_cnt - d0), 32'd0);

        $display("[TB] both requesting continuously");
        idle(4);
        va = 16'h0200; da = 16'h0300;
        for (int i = 0; i < 27; i++) begin
            applyStimulus(1'b0, 1'b1, va, 1'b1, da);
            @(negedge clk);
            checkOutput("t2_dmp_gnt", 32'(dmp_gnt), 32'((i % 9) == 8));
            checkOutput("t2_starved", 32'(starved), 32'((i % 9) == 8));
            if (vga_gnt) va++;
            if (dmp_gnt) da++;
        end

        $display("[TB] V half rate, D continuous");
        idle(4);
        da = 16'h0400;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'((i % 2) == 0), 16'(i), 1'b1, da);
            @(negedge clk);
            checkOutput("t3_vga_gnt", 32'(vga_gnt), 32'((i % 2) == 0));
            checkOutput("t3_dmp_gnt", 32'(dmp_gnt), 32'((i % 2) != 0));
            checkOutput("t3_starved", 32'(starved), 32'd0);
            if (dmp_gnt) da++;
        end

        $display("[TB] 64-pixel dump during scan-out");
        idle(4);
        d0 = dmp_rv_cnt;
        dumped = 0;
        for (int i = 0; i < 400 && dumped < 64; i++) begin
            applyStimulus(1'b0, 1'((i % 2) == 0), 16'(16'h0800 + i), 1'b1, 16'(16'h0100 + dumped));
            @(negedge clk);
            if (dmp_gnt) dumped++;
        end
        idle(MEM_LAT + 3);
        checkOutput("t4_dump_grants", 32'(dumped), 32'd64);
        checkOutput("t4_dump_returns", 32'(dmp_rv_cnt - d0), 32'd64);

        $display("[TB] clear with two reads in flight");
        idle(4);
        v0 = vga_rv_cnt; d0 = dmp_rv_cnt;
        applyStimulus(1'b0, 1'b1, 16'd10, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'd11);
        applyStimulus(1'b1, 1'b1, 16'd12, 1'b1, 16'd13);
        @(negedge clk);
        checkOutput("t5_clr_gnt", 32'({vga_gnt, dmp_gnt}), 32'd0);
        checkOutput("t5_clr_mem_en", 32'(mem_en), 32'd0);
        checkOutput("t5_clr_mem_addr", 32'(mem_addr), 32'd0);
        idle(MEM_LAT + 3);
        checkOutput("t5_no_vga_ret", 32'(vga_rv_cnt - v0), 32'd0);
        checkOutput("t5_no_dmp_ret", 32'(dmp_rv_cnt - d0), 32'd0);
        checkOutput("t5_vga_rdata0", 32'(vga_rdata), 32'd0);
        checkOutput("t5_dmp_rdata0", 32'(dmp_rdata), 32'd0);
        checkOutput("t5_starved0", 32'(starved), 32'd0);
        applyStimulus(1'b0, 1'b1, 16'd2, 1'b0, '0);
        idle(MEM_LAT + 2);
        checkOutput("t5_post_ret", 32'(vga_rv_cnt - v0), 32'd1);
        if (vga_data_seen.size() > 0)
            checkOutput("t5_post_data", 32'(vga_data_seen[$]), 32'd7);

        $display("[TB] randomized traffic");
        idle(4);
        vr = 1'b0; dr = 1'b0; va = '0; da = '0;
        for (int i = 0; i < 3000; i++) begin
            if (vg_seen || !vr) begin
                vr = ($urandom_range(0, 99) < ((i < 1500) ? 95 : 50));
                va = 16'($urandom);
            end
            if (dg_seen || !dr) begin
                dr = ($urandom_range(0, 99) < 70);
                da = 16'($urandom);
            end
            applyStimulus(1'(($urandom % 300) == 0), vr, va, dr, da);
        end
        idle(MEM_LAT + 4);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
